// File: rtl/encoder_fixed_point_seq.sv
// Sequential fixed-point dense layer: out[i] = b[i] + sum_j x[j]*w[j][i], one MAC per cycle.
// Optional macro ENCODER_SATURATE_EN clamps oversized results instead of wrapping them.
module encoder_fixed_point_seq #(
    parameter int N_input  = 9,
    parameter int M_output = 2,
    parameter int BITSIZE  = 32
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic                           start,
    input  logic [N_input*BITSIZE-1:0]          x,
    input  logic [N_input*M_output*BITSIZE-1:0] w,
    input  logic [M_output*BITSIZE-1:0]         b,
    output logic                           busy,
    output logic                           done,
    output logic [M_output*BITSIZE-1:0]    out
);
    localparam int FB  = BITSIZE - 5;
    localparam int PW  = 2 * (BITSIZE - 1);
    localparam int AW0 = (BITSIZE + N_input > 48) ? BITSIZE + N_input : 48;
    localparam int AWP = BITSIZE + 5 + $clog2(N_input + 1);
    localparam int AW  = (AW0 > AWP) ? AW0 : AWP;
    localparam int IW  = (M_output > 1) ? $clog2(M_output) : 1;
    localparam int JW  = (N_input > 1) ? $clog2(N_input) : 1;

    typedef enum logic [1:0] {IDLE, MAC, STORE, FINISH} state_t;

    state_t            state, state_nxt;
    logic [AW-1:0]     acc;
    logic [IW-1:0]     i;
    logic [JW-1:0]     j;

    logic [BITSIZE-1:0] xj, wji, bnext;
    logic [PW-1:0]      prod_mag, prod_sh;
    logic [AW-1:0]      prod_tc, acc_abs;
    logic [BITSIZE-2:0] mag;
    logic [BITSIZE-1:0] conv;
    logic               last_j, last_i;
    int                 bidx;

    function automatic logic [AW-1:0] sm_to_tc(input logic [BITSIZE-1:0] v);
        logic [AW-1:0] m;
        m = AW'(v[BITSIZE-2:0]);
        return v[BITSIZE-1] ? -m : m;
    endfunction

    assign last_j = (j == JW'(N_input - 1));
    assign last_i = (i == IW'(M_output - 1));
    // bidx is clamped so the bias select never runs past the port on the last output
    assign bidx   = last_i ? 0 : int'(i) + 1;
    assign xj     = x[int'(j)*BITSIZE +: BITSIZE];
    assign wji    = w[(int'(i)*N_input + int'(j))*BITSIZE +: BITSIZE];
    assign bnext  = b[bidx*BITSIZE +: BITSIZE];

    // Magnitude product truncated toward zero before the sign is applied
    assign prod_mag = PW'(xj[BITSIZE-2:0]) * PW'(wji[BITSIZE-2:0]);
    assign prod_sh  = prod_mag >> FB;
    assign prod_tc  = (xj[BITSIZE-1] ^ wji[BITSIZE-1]) ? -AW'(prod_sh) : AW'(prod_sh);

    assign acc_abs = acc[AW-1] ? -acc : acc;
`ifdef ENCODER_SATURATE_EN
    assign mag = (|acc_abs[AW-1:BITSIZE-1]) ? '1 : acc_abs[BITSIZE-2:0];
`else
    assign mag = acc_abs[BITSIZE-2:0];
`endif
    assign conv = {acc[AW-1] && (mag != '0), mag};

    always_ff @(posedge clk) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start) state_nxt = MAC;
            MAC:     if (last_j) state_nxt = STORE;
            STORE:   state_nxt = last_i ? FINISH : MAC;
            FINISH:  state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        busy = (state != IDLE);
        done = (state == FINISH);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            acc <= '0;
            i   <= '0;
            j   <= '0;
            out <= '0;
        end else begin
            case (state)
                IDLE: if (start) begin
                    acc <= sm_to_tc(b[BITSIZE-1:0]);
                    i   <= '0;
                    j   <= '0;
                end
                MAC: begin
                    acc <= acc + prod_tc;
                    j   <= j + 1'b1;
                end
                STORE: begin
                    out[int'(i)*BITSIZE +: BITSIZE] <= conv;
                    if (!last_i) begin
                        acc <= sm_to_tc(bnext);
                        i   <= i + 1'b1;
                        j   <= '0;
                    end
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_encoder_fixed_point_seq.sv
// Table-driven bench with an expected-result queue for encoder_fixed_point_seq.
module tb_encoder_fixed_point_seq;
    localparam int N = 9;
    localparam int M = 2;
    localparam int B = 32;
`ifdef ENCODER_SATURATE_EN
    localparam logic [31:0] BIG_POS = 32'h7FFFFFFF;
    localparam logic [31:0] BIG_NEG = 32'hFFFFFFFF;
`else
    localparam logic [31:0] BIG_POS = 32'h00000000;
    localparam logic [31:0] BIG_NEG = 32'h00000000;
`endif

    logic             clk = 1'b0;
    logic             rst_n, start;
    logic [N*B-1:0]   x;
    logic [N*M*B-1:0] w;
    logic [M*B-1:0]   b;
    logic             busy, done;
    logic [M*B-1:0]   out;

    encoder_fixed_point_seq #(.N_input(N), .M_output(M), .BITSIZE(B)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .x(x), .w(w), .b(b),
        .busy(busy), .done(done), .out(out)
    );

    always #5 clk = ~clk;

    typedef struct {
        string            name;
        logic [N*B-1:0]   x;
        logic [N*M*B-1:0] w;
        logic [M*B-1:0]   b;
        logic [M*B-1:0]   exp;
    } vec_t;

    localparam int NV = 7;
    vec_t           tv [NV];
    logic [M*B-1:0] exp_q [$];
    int             n_chk = 0;
    int             n_pass = 0;

    task automatic check(input string nm, input logic [63:0] got, input logic [63:0] want);
        n_chk++;
        if (got === want) n_pass++;
        else $display("FAIL %s: got %h want %h", nm, got, want);
    endtask

    function automatic int wi(input int j, input int i);
        return (i*N + j)*B;
    endfunction

    task automatic apply(input int k);
        x = tv[k].x;
        w = tv[k].w;
        b = tv[k].b;
    endtask

    task automatic pop_check(input string nm);
        logic [M*B-1:0] e;
        if (exp_q.size() == 0) begin
            check({nm, " queue"}, 64'd1, 64'd0);
        end else begin
            e = exp_q.pop_front();
            check({nm, " out"}, out, e);
        end
    endtask

    // Start at edge 0, expect done in the cycle after edge 20
    task automatic run_vec(input int k);
        int e;
        apply(k);
        @(negedge clk) start = 1'b1;
        exp_q.push_back(tv[k].exp);
        @(posedge clk); #1 start = 1'b0;
        check({tv[k].name, " busy"}, busy, 1);
        e = 0;
        while (e < 40) begin
            @(posedge clk); #1 e++;
            if (done) break;
        end
        check({tv[k].name, " done_edge"}, e, 20);
        if (done) begin
            pop_check(tv[k].name);
            @(posedge clk); #1;
            check({tv[k].name, " done_pulse"}, done, 0);
        end else begin
            void'(exp_q.pop_front());
        end
    endtask

    initial begin
        int ndone, dedge, dedge2;
        for (int k = 0; k < NV; k++) begin
            tv[k].x = '0; tv[k].w = '0; tv[k].b = '0; tv[k].exp = '0;
        end
        tv[0].name = "basic";
        tv[0].x[0 +: 32] = 32'h08000000; tv[0].x[32 +: 32] = 32'h84000000;
        tv[0].w[wi(0,0) +: 32] = 32'h04000000; tv[0].w[wi(1,0) +: 32] = 32'h08000000;
        tv[0].b[0 +: 32] = 32'h02000000;
        tv[0].exp = {32'h00000000, 32'h02000000};
        tv[1] = tv[0];
        tv[1].name = "neg_bias";
        tv[1].b[32 +: 32] = 32'h82000000;
        tv[1].exp = {32'h82000000, 32'h02000000};
        tv[2].name = "overflow_pos";
        tv[2].x[0 +: 32] = 32'h40000000; tv[2].w[wi(0,0) +: 32] = 32'h40000000;
        tv[2].exp = {32'h00000000, BIG_POS};
        tv[3].name = "no_neg_zero";
        tv[3].x[0 +: 32] = 32'h08000000; tv[3].w[wi(0,0) +: 32] = 32'h88000000;
        tv[3].b[0 +: 32] = 32'h08000000;
        tv[3].exp = '0;
        tv[4].name = "trunc_zero";
        tv[4].x[0 +: 32] = 32'h80000003;
        tv[4].w[wi(0,0) +: 32] = 32'h04000000; tv[4].w[wi(0,1) +: 32] = 32'h08000000;
        tv[4].exp = {32'h80000003, 32'h80000001};
        tv[5].name = "last_input";
        tv[5].x[8*32 +: 32] = 32'h10000000;
        tv[5].w[wi(8,0) +: 32] = 32'h84000000; tv[5].w[wi(8,1) +: 32] = 32'h0C000000;
        tv[5].b[32 +: 32] = 32'h88000000;
        tv[5].exp = {32'h10000000, 32'h88000000};
        tv[6].name = "overflow_neg";
        tv[6].x[0 +: 32] = 32'hC0000000; tv[6].w[wi(0,0) +: 32] = 32'h40000000;
        tv[6].exp = {32'h00000000, BIG_NEG};

        // Reset wins over a concurrent start
        rst_n = 1'b0; start = 1'b1; apply(0);
        repeat (3) @(posedge clk);
        #1;
        check("rst busy", busy, 0);
        check("rst done", done, 0);
        check("rst out", out, 0);
        @(negedge clk) begin rst_n = 1'b1; start = 1'b0; end

        for (int k = 0; k < NV; k++) run_vec(k);

        // Second start inside a run is ignored
        apply(0);
        @(negedge clk) start = 1'b1;
        exp_q.push_back(tv[0].exp);
        @(posedge clk); #1 start = 1'b0;
        ndone = 0; dedge = 0;
        for (int e = 1; e <= 30; e++) begin
            @(posedge clk); #1;
            if (e == 4) start = 1'b1;
            if (e == 5) start = 1'b0;
            if (done) begin
                ndone++; dedge = e;
                pop_check("restart_ignored");
            end
        end
        check("restart_ignored ndone", ndone, 1);
        check("restart_ignored edge", dedge, 20);

        // Reset at edge 10 aborts the run
        apply(1);
        @(negedge clk) start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        for (int e = 1; e <= 9; e++) begin
            @(posedge clk); #1;
        end
        rst_n = 1'b0;
        @(posedge clk); #1;
        check("abort busy", busy, 0);
        check("abort out", out, 0);
        check("abort done", done, 0);
        @(negedge clk) rst_n = 1'b1;
        ndone = 0;
        for (int e = 0; e < 30; e++) begin
            @(posedge clk); #1;
            if (done) ndone++;
        end
        check("abort no_done", ndone, 0);
        run_vec(1);

        // Start held high: second run accepted in the IDLE cycle after FINISH
        apply(4);
        @(negedge clk) start = 1'b1;
        exp_q.push_back(tv[4].exp);
        exp_q.push_back(tv[3].exp);
        @(posedge clk); #1;
        ndone = 0; dedge = 0; dedge2 = 0;
        for (int e = 1; e <= 50; e++) begin
            @(posedge clk); #1;
            if (done) begin
                ndone++;
                if (ndone == 1) dedge = e; else dedge2 = e;
                pop_check("b2b");
            end
            if (e == 20) check("b2b busy_finish", busy, 1);
            if (e == 21) begin
                check("b2b busy_idle", busy, 0);
                apply(3);
            end
            if (e == 22) begin
                check("b2b accepted", busy, 1);
                start = 1'b0;
            end
            if (e == 31) check("b2b held", out, tv[4].exp);
            if (e == 32) check("b2b store0", out, {tv[4].exp[63:32], tv[3].exp[31:0]});
        end
        check("b2b ndone", ndone, 2);
        check("b2b edge1", dedge, 20);
        check("b2b edge2", dedge2, 42);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
